// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Separable switch allocator for a wormhole mesh router.
//               Each output port runs an IDLE/LOCKED FSM with a registered
//               owner and round-robin pointer. Grants are combinational from
//               the registered state and the current requests.
//               Optional macro SA_NO_UTURN_EN: when defined, requests from
//               input i to output i (i >= 1) are masked out.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef N
`define N 5
`endif

module switch_allocator #(
    parameter int N_PORTS = `N,
    parameter int X_LOC   = 0,
    parameter int Y_LOC   = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [0:N_PORTS-1][0:N_PORTS-1]           i_output_req,
    input  logic [0:N_PORTS-1]                        i_valid,
    input  logic [0:N_PORTS-1]                        i_tail,
    input  logic [0:N_PORTS-1]                        i_credit_avail,
    output logic [0:N_PORTS-1][0:N_PORTS-1]           o_grant,
    output logic [0:N_PORTS-1]                        o_read_en,
    output logic [0:N_PORTS-1][$clog2(N_PORTS)-1:0]   o_xbar_sel,
    output logic [0:N_PORTS-1]                        o_xbar_valid,
    output logic [0:N_PORTS-1]                        o_locked
);

    localparam int c_SEL_W = $clog2(N_PORTS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Coordinates only identify the node; nothing depends on them.
    if (X_LOC < 0 || Y_LOC < 0) begin : g_coord_check
    end

    state_t               r_state [N_PORTS];
    logic [c_SEL_W-1:0]   r_owner [N_PORTS];
    logic [c_SEL_W-1:0]   r_ptr   [N_PORTS];
    logic [c_SEL_W-1:0]   r_sel   [N_PORTS];

    logic [0:N_PORTS-1][0:N_PORTS-1] w_eff;
    logic [0:N_PORTS-1]              w_busy;
    logic [0:N_PORTS-1][0:N_PORTS-1] w_grant;
    logic [0:N_PORTS-1]              w_xvalid;
    logic [c_SEL_W-1:0]              w_win  [N_PORTS];
    logic [c_SEL_W-1:0]              w_next [N_PORTS];
    logic                            w_seen;
    int                              w_cand;

    // Effective requests: lowest set bit of each row, qualified by valid and credit.
    always_comb begin
        w_eff  = '0;
        w_seen = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_seen = 1'b0;
            for (int j = 0; j < N_PORTS; j++) begin
                if (i_output_req[i][j] && !w_seen) begin
                    w_seen      = 1'b1;
                    w_eff[i][j] = i_valid[i] & i_credit_avail[j];
`ifdef SA_NO_UTURN_EN
                    if (i == j && i != 0) begin
                        w_eff[i][j] = 1'b0;
                    end
`endif
                end
            end
        end
    end

    // An input that owns a locked output may not win any other output.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (r_state[j] == ST_LOCKED && r_owner[j] == c_SEL_W'(i)) begin
                    w_busy[i] = 1'b1;
                end
            end
        end
    end

    // Per-output arbitration: owner-only when locked, round-robin from ptr when idle.
    always_comb begin
        w_grant  = '0;
        w_xvalid = '0;
        w_cand   = 0;
        for (int j = 0; j < N_PORTS; j++) begin
            w_win[j] = r_sel[j];
            if (r_state[j] == ST_LOCKED) begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (r_owner[j] == c_SEL_W'(i) && w_eff[i][j]) begin
                        w_grant[i][j] = 1'b1;
                        w_xvalid[j]   = 1'b1;
                        w_win[j]      = c_SEL_W'(i);
                    end
                end
            end else begin
                for (int k = 0; k < N_PORTS; k++) begin
                    w_cand = int'(r_ptr[j]) + k;
                    if (w_cand >= N_PORTS) begin
                        w_cand = w_cand - N_PORTS;
                    end
                    if (!w_xvalid[j] && w_eff[w_cand][j] && !w_busy[w_cand]) begin
                        w_grant[w_cand][j] = 1'b1;
                        w_xvalid[j]        = 1'b1;
                        w_win[j]           = c_SEL_W'(w_cand);
                    end
                end
            end
            w_next[j] = (w_win[j] == c_SEL_W'(N_PORTS - 1)) ? '0 : w_win[j] + 1'b1;
        end
    end

    // Output drive; reset forces everything quiet in the same cycle.
    always_comb begin
        o_grant      = reset ? '0 : w_grant;
        o_xbar_valid = reset ? '0 : w_xvalid;
        o_read_en    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            o_read_en[i] = |o_grant[i];
        end
        for (int j = 0; j < N_PORTS; j++) begin
            o_locked[j]   = !reset && (r_state[j] == ST_LOCKED);
            o_xbar_sel[j] = reset ? '0 : (w_xvalid[j] ? w_win[j] : r_sel[j]);
        end
    end

    // Output FSMs: lock on a non-tail head, release and advance ptr on a tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_PORTS; j++) begin
                r_state[j] <= ST_IDLE;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
                r_sel[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < N_PORTS; j++) begin
                r_sel[j] <= o_xbar_sel[j];
                if (w_xvalid[j]) begin
                    if (r_state[j] == ST_LOCKED) begin
                        if (i_tail[w_win[j]]) begin
                            r_state[j] <= ST_IDLE;
                            r_ptr[j]   <= w_next[j];
                        end
                    end else if (i_tail[w_win[j]]) begin
                        r_ptr[j] <= w_next[j];
                    end else begin
                        r_state[j] <= ST_LOCKED;
                        r_owner[j] <= w_win[j];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Self-checking bench for switch_allocator: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_switch_allocator;

    localparam int NP = 5;
    localparam int SW = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [0:NP-1][0:NP-1]      i_output_req;
    logic [0:NP-1]              i_valid;
    logic [0:NP-1]              i_tail;
    logic [0:NP-1]              i_credit_avail;
    logic [0:NP-1][0:NP-1]      o_grant;
    logic [0:NP-1]              o_read_en;
    logic [0:NP-1][SW-1:0]      o_xbar_sel;
    logic [0:NP-1]              o_xbar_valid;
    logic [0:NP-1]              o_locked;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model state
    bit  m_locked [NP];
    int  m_owner  [NP];
    int  m_ptr    [NP];
    int  m_sel    [NP];
    int  e_win    [NP];
    logic [0:NP-1][0:NP-1] e_grant;
    logic [0:NP-1]         e_rd;
    logic [0:NP-1]         e_vld;
    logic [0:NP-1]         e_lk;
    logic [0:NP-1][SW-1:0] e_sel;
    logic                  exp_uturn;

    switch_allocator #(
        .N_PORTS(NP),
        .X_LOC  (1),
        .Y_LOC  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_output_req  (i_output_req),
        .i_valid       (i_valid),
        .i_tail        (i_tail),
        .i_credit_avail(i_credit_avail),
        .o_grant       (o_grant),
        .o_read_en     (o_read_en),
        .o_xbar_sel    (o_xbar_sel),
        .o_xbar_valid  (o_xbar_valid),
        .o_locked      (o_locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the allocation rules, given model state and inputs.
    task automatic model_eval();
        int  tgt  [NP];
        bit  eff  [NP];
        bit  busy [NP];
        int  c;
        for (int i = 0; i < NP; i++) begin
            tgt[i] = -1;
            for (int j = NP - 1; j >= 0; j--) begin
                if (i_output_req[i][j]) tgt[i] = j;
            end
            eff[i] = 1'b0;
            if (i_valid[i] && tgt[i] >= 0) begin
                eff[i] = i_credit_avail[tgt[i]];
            end
`ifdef SA_NO_UTURN_EN
            if (tgt[i] == i && i > 0) eff[i] = 1'b0;
`endif
            busy[i] = 1'b0;
            for (int j = 0; j < NP; j++) begin
                if (m_locked[j] && m_owner[j] == i) busy[i] = 1'b1;
            end
        end
        e_grant = '0;
        e_rd    = '0;
        e_vld   = '0;
        e_lk    = '0;
        e_sel   = '0;
        for (int j = 0; j < NP; j++) begin
            e_win[j] = -1;
            if (m_locked[j]) begin
                if (eff[m_owner[j]] && tgt[m_owner[j]] == j) e_win[j] = m_owner[j];
            end else begin
                for (int k = 0; k < NP; k++) begin
                    c = (m_ptr[j] + k) % NP;
                    if (e_win[j] < 0 && eff[c] && tgt[c] == j && !busy[c]) e_win[j] = c;
                end
            end
            if (reset) e_win[j] = -1;
            if (e_win[j] >= 0) begin
                e_grant[e_win[j]][j] = 1'b1;
                e_vld[j] = 1'b1;
            end
            e_sel[j] = reset ? SW'(0) : (e_win[j] >= 0 ? SW'(e_win[j]) : SW'(m_sel[j]));
            e_lk[j]  = !reset && m_locked[j];
        end
        for (int i = 0; i < NP; i++) e_rd[i] = |e_grant[i];
    endtask

    // Advance the model at the clock edge.
    task automatic model_update();
        int w;
        for (int j = 0; j < NP; j++) begin
            if (reset) begin
                m_locked[j] = 1'b0;
                m_owner[j]  = 0;
                m_ptr[j]    = 0;
                m_sel[j]    = 0;
            end else if (e_win[j] >= 0) begin
                w = e_win[j];
                m_sel[j] = w;
                if (m_locked[j]) begin
                    if (i_tail[w]) begin
                        m_locked[j] = 1'b0;
                        m_ptr[j]    = (w + 1) % NP;
                    end
                end else if (i_tail[w]) begin
                    m_ptr[j] = (w + 1) % NP;
                end else begin
                    m_locked[j] = 1'b1;
                    m_owner[j]  = w;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        check("grant",      o_grant,      e_grant);
        check("read_en",    o_read_en,    e_rd);
        check("xbar_valid", o_xbar_valid, e_vld);
        check("xbar_sel",   o_xbar_sel,   e_sel);
        check("locked",     o_locked,     e_lk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        i_valid        = '0;
        i_tail         = '0;
        i_output_req   = '0;
        i_credit_avail = '1;
    endtask

    task automatic req(input int i, input int j, input bit tail);
        i_valid[i]         = 1'b1;
        i_tail[i]          = tail;
        i_output_req[i]    = '0;
        i_output_req[i][j] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        for (int j = 0; j < NP; j++) begin
            m_locked[j] = 1'b0; m_owner[j] = 0; m_ptr[j] = 0; m_sel[j] = 0;
        end
        req(1, 2, 1'b1);
        req(2, 4, 1'b0);
        @(posedge clk); #1;

        // Reset forces outputs low even with live requests
        sample();
        check("rst_grant",  o_grant,      '0);
        check("rst_locked", o_locked,     '0);
        check("rst_valid",  o_xbar_valid, '0);
        advance();
        reset = 1'b0;

        // Two single-flit requesters on output 2
        clear_in();
        req(1, 2, 1'b1);
        req(3, 2, 1'b1);
        sample();
        check("rr_in1_first", o_grant[1][2], 1'b1);
        check("rr_in3_waits", o_grant[3][2], 1'b0);
        advance();
        i_valid[1] = 1'b0;
        sample();
        check("rr_in3_second", o_grant[3][2], 1'b1);
        check("rr_sel3",       o_xbar_sel[2], 3'd3);
        advance();
        clear_in();
        req(0, 2, 1'b1);
        req(3, 2, 1'b1);
        req(4, 2, 1'b1);
        sample();
        check("rr_ptr_at_4", o_grant[4][2], 1'b1);
        advance();
        clear_in();
        sample();
        check("sel_hold",       o_xbar_sel[2],   3'd4);
        check("sel_hold_valid", o_xbar_valid[2], 1'b0);
        advance();

        // Multi-flit packet from in2 locks output 4 against in1
        req(2, 4, 1'b0);
        sample();
        check("pkt_head",      o_grant[2][4], 1'b1);
        check("pkt_head_idle", o_locked[4],   1'b0);
        advance();
        req(1, 4, 1'b1);
        sample();
        check("pkt_body",     o_grant[2][4], 1'b1);
        check("pkt_blocks",   o_grant[1][4], 1'b0);
        check("pkt_locked",   o_locked[4],   1'b1);
        advance();
        i_valid[2] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            sample();
            check("bubble_locked", o_locked[4],     1'b1);
            check("bubble_in1",    o_read_en[1],    1'b0);
            check("bubble_nogrt",  o_xbar_valid[4], 1'b0);
            advance();
        end
        i_valid[2] = 1'b1;
        i_tail[2]  = 1'b1;
        sample();
        check("pkt_tail", o_grant[2][4], 1'b1);
        advance();
        i_valid[2] = 1'b0;
        sample();
        check("pkt_next_in1", o_grant[1][4], 1'b1);
        check("pkt_released", o_locked[4],   1'b0);
        advance();

        // Credit gating on output 1
        clear_in();
        req(0, 1, 1'b1);
        i_credit_avail[1] = 1'b0;
        sample();
        check("no_credit", o_grant[0][1], 1'b0);
        advance();
        i_credit_avail[1] = 1'b1;
        sample();
        check("credit_back", o_grant[0][1], 1'b1);
        advance();

        // U-turn and local loopback
        clear_in();
        req(3, 3, 1'b1);
        req(0, 0, 1'b1);
`ifdef SA_NO_UTURN_EN
        exp_uturn = 1'b0;
`else
        exp_uturn = 1'b1;
`endif
        sample();
        check("uturn_3",  o_grant[3][3], exp_uturn);
        check("local_00", o_grant[0][0], 1'b1);
        advance();

        // Locked input asking elsewhere gets nothing; then reset mid-packet
        clear_in();
        req(2, 4, 1'b0);
        sample();
        advance();
        req(2, 0, 1'b1);
        sample();
        check("owner_elsewhere", o_read_en[2], 1'b0);
        check("owner_lock_kept", o_locked[4],  1'b1);
        advance();
        req(2, 4, 1'b0);
        req(1, 4, 1'b1);
        reset = 1'b1;
        sample();
        check("midrst_grant",  o_grant,  '0);
        check("midrst_locked", o_locked, '0);
        advance();
        reset = 1'b0;
        sample();
        check("postrst_in1",    o_grant[1][4], 1'b1);
        check("postrst_locked", o_locked,      '0);
        advance();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NP; i++) begin
                int kind;
                i_valid[i]        = ($urandom_range(0, 3) != 0);
                i_tail[i]         = ($urandom_range(0, 2) == 0);
                i_credit_avail[i] = ($urandom_range(0, 4) != 0);
                kind = $urandom_range(0, 9);
                i_output_req[i] = '0;
                if (kind == 1) begin
                    i_output_req[i] = NP'($urandom);
                end else if (kind > 1) begin
                    i_output_req[i][$urandom_range(0, NP - 1)] = 1'b1;
                end
            end
            sample();
            advance();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
